// File: rtl/wisc_mem_pkg.sv
// Shared definitions for the I/D-cache main-memory arbiter.
package wisc_mem_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned WORD_W      = 3;
  localparam int unsigned BLOCK_WORDS = 8;
  localparam int unsigned MEM_LATENCY = 4;

  localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    I_FILL  = 2'd1,
    D_FILL  = 2'd2,
    D_WRITE = 2'd3
  } arb_state_t;

  // Byte address of word k inside the block starting at base.
  function automatic logic [ADDR_W-1:0] block_word_addr(input logic [ADDR_W-1:0] base,
                                                        input logic [WORD_W-1:0] k);
    return base + ADDR_W'({k, 1'b0});
  endfunction

endpackage

// File: rtl/mem_word_counter.sv
// Block word counter: counts 0..BLOCK_WORDS-1, then raises a sticky terminal flag.
module mem_word_counter
  import wisc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [WORD_W-1:0] o_count,
  output logic              o_term
);

  logic [WORD_W-1:0] r_count;
  logic              r_term;

  // Saturates at the last word; the terminal flag blocks any further counting.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
      r_term  <= 1'b0;
    end else if (i_inc && !r_term) begin
      if (r_count == WORD_W'(BLOCK_WORDS - 1)) begin
        r_term <= 1'b1;
      end else begin
        r_count <= r_count + WORD_W'(1);
      end
    end
  end

  assign o_count = r_count;
  assign o_term  = r_term;

endmodule

// File: rtl/mem_arbiter.sv
// Main-memory arbiter between I-cache block fills and D-cache fills / write-throughs.
module mem_arbiter
  import wisc_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] fill_data,
  output logic [WORD_W-1:0] fill_word,
  output logic              i_fill_valid,
  output logic              d_fill_valid,
  output logic              i_busy,
  output logic              d_busy,
  output logic              i_done,
  output logic              d_done
);

  arb_state_t        r_state;
  arb_state_t        w_next;
  logic [ADDR_W-1:0] r_base;
  logic              w_fill;
  logic              w_clr;
  logic              w_iss_inc;
  logic              w_iss_term;
  logic              w_rcv_acc;
  logic              w_rcv_term;
  logic              w_last;
  logic [WORD_W-1:0] w_iss_cnt;
  logic [WORD_W-1:0] w_rcv_cnt;

  assign w_fill    = (r_state == I_FILL) || (r_state == D_FILL);
  assign w_clr     = (r_state == IDLE);
  assign w_iss_inc = w_fill && !w_iss_term;
  assign w_rcv_acc = w_fill && mem_rvalid && !w_rcv_term;
  assign w_last    = w_rcv_acc && (w_rcv_cnt == WORD_W'(BLOCK_WORDS - 1));

  mem_word_counter u_issue_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_inc   (w_iss_inc),
    .o_count (w_iss_cnt),
    .o_term  (w_iss_term)
  );

  mem_word_counter u_recv_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_clr),
    .i_inc   (w_rcv_acc),
    .o_count (w_rcv_cnt),
    .o_term  (w_rcv_term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Block base is captured at grant so a dropped or changing request cannot disturb the fill.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_base <= '0;
    end else if (r_state == IDLE) begin
      if (d_req) begin
        r_base <= d_addr & BLOCK_MASK;
      end else if (i_req) begin
        r_base <= i_addr & BLOCK_MASK;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    mem_en       = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    fill_data    = '0;
    fill_word    = '0;
    i_fill_valid = 1'b0;
    d_fill_valid = 1'b0;
    i_busy       = 1'b0;
    d_busy       = 1'b0;
    i_done       = 1'b0;
    d_done       = 1'b0;

    case (r_state)
      IDLE: begin
        i_busy = i_req;
        d_busy = d_req;
        if (d_req) begin
          w_next = d_wr ? D_WRITE : D_FILL;
        end else if (i_req) begin
          w_next = I_FILL;
        end
      end

      D_WRITE: begin
        i_busy    = i_req;
        d_busy    = 1'b1;
        mem_en    = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_done    = 1'b1;
        w_next    = IDLE;
      end

      I_FILL, D_FILL: begin
        // A waiting requester keeps its pipeline frozen while the other side is served.
        i_busy = (r_state == I_FILL) || i_req;
        d_busy = (r_state == D_FILL) || d_req;
        if (w_iss_inc) begin
          mem_en   = 1'b1;
          mem_addr = block_word_addr(r_base, w_iss_cnt);
        end
        if (w_rcv_acc) begin
          fill_data    = mem_rdata;
          fill_word    = w_rcv_cnt;
          i_fill_valid = (r_state == I_FILL);
          d_fill_valid = (r_state == D_FILL);
        end
        if (w_last) begin
          i_done = (r_state == I_FILL);
          d_done = (r_state == D_FILL);
          w_next = IDLE;
        end
      end

      default: w_next = IDLE;
    endcase

    if (rst) begin
      w_next       = IDLE;
      mem_en       = 1'b0;
      mem_wr       = 1'b0;
      mem_addr     = '0;
      mem_wdata    = '0;
      fill_data    = '0;
      fill_word    = '0;
      i_fill_valid = 1'b0;
      d_fill_valid = 1'b0;
      i_busy       = 1'b0;
      d_busy       = 1'b0;
      i_done       = 1'b0;
      d_done       = 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency memory responder plus a transaction-schedule reference model.
module tb_mem_arbiter;
  import wisc_mem_pkg::*;

  localparam int K_I = 0;
  localparam int K_D = 1;
  localparam int K_W = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req;
  logic [15:0] i_addr;
  logic        d_req;
  logic        d_wr;
  logic [15:0] d_addr;
  logic [15:0] d_wdata;
  logic [15:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_en;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] fill_data;
  logic [2:0]  fill_word;
  logic        i_fill_valid;
  logic        d_fill_valid;
  logic        i_busy;
  logic        d_busy;
  logic        i_done;
  logic        d_done;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .i_req        (i_req),
    .i_addr       (i_addr),
    .d_req        (d_req),
    .d_wr         (d_wr),
    .d_addr       (d_addr),
    .d_wdata      (d_wdata),
    .mem_rdata    (mem_rdata),
    .mem_rvalid   (mem_rvalid),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .fill_data    (fill_data),
    .fill_word    (fill_word),
    .i_fill_valid (i_fill_valid),
    .d_fill_valid (d_fill_valid),
    .i_busy       (i_busy),
    .d_busy       (d_busy),
    .i_done       (i_done),
    .d_done       (d_done)
  );

  // Main memory: hashed background contents overlaid by written words.
  logic [15:0] salt;
  logic [15:0] wdat [65536];
  bit          wvalid [65536];

  function automatic logic [15:0] mem_val(input logic [15:0] a);
    if (wvalid[a]) return wdat[a];
    return 16'(a * 16'h9E37) ^ salt;
  endfunction

  logic [MEM_LATENCY-1:0] pv;
  logic [15:0]            pd [MEM_LATENCY];
  logic                   spur;
  logic [15:0]            spur_data;

  always @(posedge clk) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[MEM_LATENCY-2:0], mem_en & ~mem_wr};
      pd[0] <= mem_val(mem_addr);
      for (int i = 1; i < int'(MEM_LATENCY); i++) pd[i] <= pd[i-1];
      if (mem_en && mem_wr) begin
        wdat[mem_addr]   <= mem_wdata;
        wvalid[mem_addr] <= 1'b1;
      end
    end
  end

  assign mem_rvalid = pv[MEM_LATENCY-1] | spur;
  assign mem_rdata  = pv[MEM_LATENCY-1] ? pd[MEM_LATENCY-1] : (spur ? spur_data : 16'h0000);

  // Reference model: one transaction at a time, timed from its grant cycle.
  int          cyc_n = 0;
  int          n_pass = 0;
  int          n_total = 0;
  bit          m_active = 1'b0;
  int          m_kind = 0;
  int          m_g = 0;
  logic [15:0] m_base = '0;
  bit          last_i_done, last_d_done;
  int          last_cyc;
  int          n_ifv, n_dfv, n_ib_low;
  logic [2:0]  first_fw;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc_n, obs, exp);
  endtask

  task automatic cyc();
    logic [15:0] e_addr, e_wdata, e_fdata;
    logic        e_en, e_wr, e_ifv, e_dfv, e_ib, e_db, e_id, e_dd, quiet;
    logic [2:0]  e_fw;
    bit          saw_i, saw_d;
    int          k;
    e_addr = '0; e_wdata = '0; e_fdata = '0; e_fw = '0;
    e_en = 0; e_wr = 0; e_ifv = 0; e_dfv = 0; e_ib = 0; e_db = 0; e_id = 0; e_dd = 0;
    quiet = 0;
    #2;
    if (rst) begin
      quiet    = 1;
      m_active = 0;
    end else if (!m_active) begin
      quiet = 1;
      e_ib  = i_req;
      e_db  = d_req;
      if (d_req) begin
        m_active = 1; m_g = cyc_n; m_kind = d_wr ? K_W : K_D; m_base = d_addr & BLOCK_MASK;
      end else if (i_req) begin
        m_active = 1; m_g = cyc_n; m_kind = K_I; m_base = i_addr & BLOCK_MASK;
      end
    end else begin
      k    = cyc_n - m_g;
      e_ib = (m_kind == K_I) || i_req;
      e_db = (m_kind != K_I) || d_req;
      if (m_kind == K_W) begin
        e_en = 1; e_wr = 1; e_addr = d_addr; e_wdata = d_wdata; e_dd = 1;
        m_active = 0;
      end else begin
        if (k <= 8) begin
          e_en   = 1;
          e_addr = m_base + 16'(2 * (k - 1));
        end
        if (k >= 5) begin
          e_fw    = 3'(k - 5);
          e_fdata = mem_val(m_base + 16'(2 * (k - 5)));
          e_ifv   = (m_kind == K_I);
          e_dfv   = (m_kind == K_D);
        end
        if (k == 12) begin
          e_id = (m_kind == K_I);
          e_dd = (m_kind == K_D);
          m_active = 0;
        end
      end
    end

    chk("mem_en",       16'(mem_en),       16'(e_en));
    chk("mem_wr",       16'(mem_wr),       16'(e_wr));
    chk("i_busy",       16'(i_busy),       16'(e_ib));
    chk("d_busy",       16'(d_busy),       16'(e_db));
    chk("i_done",       16'(i_done),       16'(e_id));
    chk("d_done",       16'(d_done),       16'(e_dd));
    chk("i_fill_valid", 16'(i_fill_valid), 16'(e_ifv));
    chk("d_fill_valid", 16'(d_fill_valid), 16'(e_dfv));
    if (e_en || quiet) chk("mem_addr", mem_addr, e_addr);
    if ((e_en && e_wr) || quiet) chk("mem_wdata", mem_wdata, e_wdata);
    if (e_ifv || e_dfv || quiet) begin
      chk("fill_data", fill_data, e_fdata);
      chk("fill_word", 16'(fill_word), 16'(e_fw));
    end

    if (i_fill_valid) begin
      if (n_ifv == 0) first_fw = fill_word;
      n_ifv++;
    end
    if (d_fill_valid) n_dfv++;
    if (!rst && !i_busy) n_ib_low++;
    saw_i = i_done;
    saw_d = d_done;

    @(posedge clk);
    #1;
    last_cyc    = cyc_n;
    cyc_n++;
    last_i_done = saw_i;
    last_d_done = saw_d;
    if (saw_i) i_req = 0;
    if (saw_d) d_req = 0;
  endtask

  task automatic wait_done(input bit for_d, input int budget, output int at);
    bit got;
    got = 0;
    at  = -1;
    for (int n = 0; n < budget && !got; n++) begin
      cyc();
      if (for_d ? last_d_done : last_i_done) begin
        got = 1;
        at  = last_cyc;
      end
    end
    chk(for_d ? "d_done_wait" : "i_done_wait", 16'(got), 16'd1);
  endtask

  initial begin
    int g, dc, ic;
    salt = 16'($urandom);
    spur = 0; spur_data = '0;
    rst = 1; i_req = 0; i_addr = '0; d_req = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
    @(posedge clk);
    #1;

    // Reset state and quiet idle
    cyc(); cyc();
    rst = 0;
    cyc(); cyc();

    // I fill of block 0x0040
    n_ifv = 0;
    i_req = 1; i_addr = 16'h0046; g = cyc_n;
    wait_done(1'b0, 20, ic);
    chk("i_fill_latency", 16'(ic - g), 16'd12);
    chk("i_fill_words",   16'(n_ifv),  16'd8);
    cyc();

    // D write-through
    d_req = 1; d_wr = 1; d_addr = 16'h2002; d_wdata = 16'hBEEF; g = cyc_n;
    wait_done(1'b1, 5, dc);
    chk("d_write_latency", 16'(dc - g), 16'd1);
    cyc();

    // Simultaneous D fill and I fill: D first, I waits with busy held
    n_ib_low = 0;
    i_req = 1; i_addr = 16'h5A5A;
    d_req = 1; d_wr = 0; d_addr = 16'h1234; g = cyc_n;
    wait_done(1'b1, 20, dc);
    chk("pair_d_latency", 16'(dc - g), 16'd12);
    wait_done(1'b0, 20, ic);
    chk("pair_i_latency", 16'(ic - g), 16'd25);
    chk("pair_i_busy_gap", 16'(n_ib_low), 16'd0);
    cyc();

    // Reset after the third word of an I fill, then restart
    n_ifv = 0;
    i_req = 1; i_addr = 16'h0A38;
    for (int n = 0; n < 20 && n_ifv < 3; n++) cyc();
    chk("i_third_word", 16'(n_ifv), 16'd3);
    rst = 1; i_req = 0;
    cyc();
    rst = 0;
    cyc(); cyc();
    n_ifv = 0;
    i_req = 1;
    wait_done(1'b0, 20, ic);
    chk("restart_first_word", 16'(first_fw), 16'd0);
    chk("restart_words",      16'(n_ifv),    16'd8);
    cyc();

    // D fill whose request drops in its fifth cycle, then a stray rvalid in IDLE
    n_dfv = 0;
    d_req = 1; d_wr = 0; d_addr = 16'h2000; g = cyc_n;
    for (int n = 0; n < 5; n++) cyc();
    d_req = 0;
    wait_done(1'b1, 20, dc);
    chk("drop_d_latency", 16'(dc - g), 16'd12);
    chk("drop_d_words",   16'(n_dfv),  16'd8);
    n_ifv = 0; n_dfv = 0;
    spur = 1; spur_data = 16'hDEAD;
    cyc();
    spur = 0;
    chk("spur_fill_valid", 16'(n_ifv + n_dfv), 16'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 2500; n++) begin
      rst  = ($urandom_range(0, 399) == 0);
      spur = 0;
      if (!i_req && $urandom_range(0, 3) == 0) begin
        i_req  = 1;
        i_addr = 16'h3000 | 16'($urandom_range(0, 255));
      end
      if (!d_req && $urandom_range(0, 3) == 0) begin
        d_req   = 1;
        d_wr    = ($urandom_range(0, 2) == 0);
        d_addr  = (16'h3000 | 16'($urandom_range(0, 255))) & 16'hFFFE;
        d_wdata = 16'($urandom);
      end
      if (m_active && $urandom_range(0, 15) == 0) begin
        if (m_kind == K_I) i_req = 0;
        else d_req = 0;
      end
      if ((!m_active || m_kind == K_W) && $urandom_range(0, 7) == 0) begin
        spur      = 1;
        spur_data = 16'($urandom);
      end
      cyc();
    end
    rst = 0; spur = 0; i_req = 0; d_req = 0;
    for (int n = 0; n < 30; n++) cyc();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 rst  in  1  synchronous, active-high reset.
REQ-003 i_req  in  1  I-cache miss fill request; held until i_done.
REQ-004 i_addr  in  16  I-cache miss address; bits [3:0] ignored.
REQ-005 d_req  in  1  D-cache request (fill or write-through); held until d_done.
REQ-006 d_wr  in  1  1 = single-word write-through, 0 = block fill; sampled with d_req.
REQ-007 d_addr  in  16  D-cache address (word-aligned for writes).
REQ-008 d_wdata  in  16  write-through data.
REQ-009 mem_rdata  in  16  main-memory read data.
REQ-010 mem_rvalid  in  1  mem_rdata valid; fixed 4-cycle latency after the read issue.
REQ-011 mem_en, mem_wr  out  1 each  main-memory enable / write strobe.
REQ-012 mem_addr, mem_wdata  out  16 each  main-memory address / write data.
REQ-013 fill_data  out  16  returned word, shared by both caches.
REQ-014 fill_word  out  3  word index (0-7) of fill_data within the block.
REQ-015 i_fill_valid, d_fill_valid  out  1 each  fill_data belongs to the I- or D-cache.
REQ-016 i_busy, d_busy  out  1 each  requester owns memory (drives the IF_stall / MEM_stall pipeline freeze).
REQ-017 i_done, d_done  out  1 each  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have states IDLE, I_FILL, D_FILL, D_WRITE.
REQ-019 Arbitration SHALL occur only in IDLE, with fixed priority: d_req beats i_req; a simultaneous pair serves D first, then I.
REQ-020 IDLE with d_req&d_wr SHALL go to D_WRITE, d_req&~d_wr to D_FILL, i_req alone to I_FILL, and no request stays in IDLE.
REQ-021 D_WRITE SHALL last exactly one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata, d_done=1, then IDLE.
REQ-022 In a fill, base = addr & 16'hFFF0; an issue counter SHALL drive mem_en=1, mem_wr=0, mem_addr=base+2k for k=0..7 on 8 consecutive cycles, starting the cycle after entry, then mem_en=0.
REQ-023 A receive counter SHALL increment on each mem_rvalid in a fill state; fill_data=mem_rdata, fill_word=count, and i_/d_fill_valid=mem_rvalid for the owner, combinationally in the same cycle.
REQ-024 On the 8th mem_rvalid (fill_word=7), the owner's done SHALL pulse in that cycle, and the next state SHALL be IDLE; fill latency is 12 cycles from entry.
REQ-025 i_busy/d_busy SHALL be 1 from the arbitration cycle through the done cycle inclusive, and 0 otherwise.
REQ-026 A request dropping mid-transaction SHALL be ignored; the transaction completes.
REQ-027 mem_rvalid SHALL be ignored in IDLE, in D_WRITE, and after 8 words are received.
REQ-028 Back-to-back transactions SHALL have at least one IDLE cycle between a done and the next grant.
REQ-029 Counters SHALL be 3 bits plus a terminal flag; no wrap beyond 7 within a transaction, and both counters clear on entry to IDLE.

Reset
REQ-030 With rst=1 at a clock edge, state SHALL be IDLE and the counters 0, including mid-transaction.
REQ-031 All outputs SHALL be 0 during and after reset until a new grant.
REQ-032 Main memory shares rst, so no stale mem_rvalid arrives after reset.

Structure
REQ-033 A shared package wisc_mem_pkg SHALL hold the state enum, BLOCK_WORDS=8, MEM_LATENCY=4, and BLOCK_MASK=16'hFFF0.
REQ-034 One sub-module, mem_word_counter (3-bit counter with clear, increment enable, and terminal flag), SHALL be instantiated twice: issue and receive.

Verification
REQ-035 i_req=1, i_addr=16'h0046 -> mem_addr 0040,0042,...,004E over 8 cycles; i_fill_valid 8 times with fill_word 0..7; i_done 12 cycles after grant.
REQ-036 i_req and d_req (d_wr=0, d_addr=16'h1234) rise together -> D_FILL of base 1230 first, with d_done; then IDLE, then I_FILL; i_busy stays 1 throughout.
REQ-037 d_req=1, d_wr=1, d_addr=16'h2002, d_wdata=16'hBEEF -> one cycle mem_en=1, mem_wr=1, addr 2002, data BEEF, d_done=1 the same cycle.
REQ-038 rst=1 after the 3rd mem_rvalid of an I fill -> next cycle all outputs 0 and IDLE; a re-request restarts at fill_word 0.
REQ-039 d_req drops during the 5th cycle of a D fill -> all 8 words are still returned and d_done pulses; a spurious mem_rvalid in IDLE causes no fill_valid.
